instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 39 +++
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-side bus: instruction-memory request/response and decode handshake.
// master = fetch unit, slave = memory/decode environment.
interface instr_fetch_if #(
  parameter int DW = 32
);
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [DW-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic [DW-1:0] imem_resp_data;
  logic          dec_valid;
  logic          dec_ready;
  logic [DW-1:0] dec_instr;
  logic [DW-1:0] dec_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    output dec_valid,
    output dec_instr,
    output dec_pc,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    input  dec_valid,
    input  dec_instr,
    input  dec_pc,
    output dec_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited requests, in-flight PC tags,
// 2-entry output FIFO to decode, flush with late-response dropping.
module instr_fetch #(
  parameter int DW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  pc_i,
  output logic           pc_en,
  input  logic           flush,
  instr_fetch_if.master  bus
);

  logic [1:0]    out_q, out_d;
  logic [1:0]    drop_q, drop_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [2:0]    credit;
  logic          acc, resp, enq, deq;

  logic [DW-1:0] iq_q [2];
  logic          iq_wr_q, iq_rd_q;

  logic [DW-1:0] fpc_q [2];
  logic [DW-1:0] fdat_q [2];
  logic          f_wr_q, f_rd_q;

  // Credits cover both in-flight requests and buffered results.
  assign credit = {1'b0, out_q} + {1'b0, cnt_q};

  assign bus.imem_req_valid = !rst && !flush && (credit < 3'd2);
  assign bus.imem_req_addr  = pc_i;
  assign acc   = bus.imem_req_valid && bus.imem_req_ready;
  assign pc_en = acc;

  assign resp = bus.imem_resp_valid && (out_q != 2'd0);
  assign enq  = resp && (drop_q == 2'd0) && !flush;
  assign deq  = bus.dec_valid && bus.dec_ready && !flush;

  assign bus.dec_valid = !rst && (cnt_q != 2'd0);
  assign bus.dec_instr = fdat_q[f_rd_q];
  assign bus.dec_pc    = fpc_q[f_rd_q];

  always_comb begin
    out_d  = out_q + {1'b0, acc} - {1'b0, resp};
    drop_d = drop_q;
    cnt_d  = cnt_q + {1'b0, enq} - {1'b0, deq};
    if (flush) begin
      drop_d = out_q - {1'b0, resp};
      cnt_d  = 2'd0;
    end else if (resp && (drop_q != 2'd0)) begin
      drop_d = drop_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= 2'd0;
      drop_q    <= 2'd0;
      cnt_q     <= 2'd0;
      iq_wr_q   <= 1'b0;
      iq_rd_q   <= 1'b0;
      f_wr_q    <= 1'b0;
      f_rd_q    <= 1'b0;
      fpc_q[0]  <= '0;
      fpc_q[1]  <= '0;
      fdat_q[0] <= '0;
      fdat_q[1] <= '0;
    end else begin
      out_q  <= out_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      if (acc)  iq_wr_q <= ~iq_wr_q;
      if (resp) iq_rd_q <= ~iq_rd_q;
      if (flush) begin
        f_wr_q <= 1'b0;
        f_rd_q <= 1'b0;
      end else begin
        if (enq) begin
          fpc_q[f_wr_q]  <= iq_q[iq_rd_q];
          fdat_q[f_wr_q] <= bus.imem_resp_data;
          f_wr_q         <= ~f_wr_q;
        end
        if (deq) f_rd_q <= ~f_rd_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) iq_q[iq_wr_q] <= pc_i;
  end

  // A response with nothing outstanding is a memory protocol error.
  a_orphan_resp: assert property (
    @(posedge clk) disable iff (rst)
    !(bus.imem_resp_valid && (out_q == 2'd0))
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory model with 1-cycle
// responses, auto-advancing PC, directed flush/reset scenarios.
module tb_instr_fetch;
  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [DW-1:0] pc_i;
  logic          pc_en;

  instr_fetch_if #(.DW(DW)) bus ();

  instr_fetch #(.DW(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .pc_i  (pc_i),
    .pc_en (pc_en),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ent_t        sbq[$];
  logic [31:0] mq[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_dec = 0;
  bit          mem_hold = 1'b0;
  logic [31:0] last_pc = '0;

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return (a == 32'h0) ? 32'h00500093 : ((a << 8) | 32'h13);
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the negedge: score the cycle, then drive the next one.
  task automatic step();
    bit   acc;
    bit   hs;
    ent_t e;
    acc = bus.imem_req_valid && bus.imem_req_ready;
    hs  = bus.dec_valid && bus.dec_ready && !flush;
    if (rst) begin
      sbq.delete();
      mq.delete();
    end else begin
      if (hs) begin
        n_dec++;
        if (sbq.size() == 0) begin
          check("sb_extra", 64'(sbq.size()), 64'd1);
        end else begin
          e = sbq.pop_front();
          check("sb_pc", 64'(bus.dec_pc), 64'(e.pc));
          check("sb_instr", 64'(bus.dec_instr), 64'(e.ins));
          last_pc = bus.dec_pc;
        end
      end
      if (flush) sbq.delete();
      if (acc) begin
        n_acc++;
        sbq.push_back({pc_i, mem_rd(pc_i)});
        mq.push_back(pc_i);
      end
    end
    @(posedge clk);
    #1;
    if (acc) pc_i = pc_i + 32'd4;
    bus.imem_resp_valid = 1'b0;
    if (!mem_hold && mq.size() > 0) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_rd(mq.pop_front());
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sbq.size() == 0 && mq.size() == 0) break;
      tick();
    end
    check("drain", 64'(sbq.size() + mq.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit %0t reached, limit 100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int d0;
    int n;
    rst                 = 1'b1;
    flush               = 1'b0;
    pc_i                = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.dec_ready       = 1'b0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("rst_pc_en", 64'(pc_en), 64'd0);
    check("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
    check("rst_dec_instr", 64'(bus.dec_instr), 64'd0);
    check("rst_dec_pc", 64'(bus.dec_pc), 64'd0);
    step();
    rst = 1'b0;

    // Single fetch
    pc_i = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.dec_ready = 1'b1;
    @(negedge clk);
    check("one_pc_en_c0", 64'(pc_en), 64'd1);
    step();
    bus.imem_req_ready = 1'b0;
    @(negedge clk);
    check("one_dv_c1", 64'(bus.dec_valid), 64'd0);
    step();
    @(negedge clk);
    check("one_dv_c2", 64'(bus.dec_valid), 64'd1);
    check("one_pc_c2", 64'(bus.dec_pc), 64'h0);
    check("one_ins_c2", 64'(bus.dec_instr), 64'h00500093);
    step();
    drain();

    // Backpressure
    bus.dec_ready = 1'b0;
    bus.imem_req_ready = 1'b1;
    pc_i = 32'h100;
    a0 = n_acc;
    repeat (6) tick();
    check("bp_acc", 64'(n_acc - a0), 64'd2);
    @(negedge clk);
    check("bp_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("bp_pc_en", 64'(pc_en), 64'd0);
    check("bp_dv", 64'(bus.dec_valid), 64'd1);
    check("bp_pc", 64'(bus.dec_pc), 64'h100);
    check("bp_ins", 64'(bus.dec_instr), 64'(mem_rd(32'h100)));
    step();
    repeat (3) tick();
    @(negedge clk);
    check("bp_pc_hold", 64'(bus.dec_pc), 64'h100);
    check("bp_ins_hold", 64'(bus.dec_instr), 64'(mem_rd(32'h100)));
    step();
    bus.dec_ready = 1'b1;
    a0 = n_acc;
    repeat (4) tick();
    check("bp_resume", 64'(n_acc > a0), 64'd1);
    bus.imem_req_ready = 1'b0;
    drain();

    // Flush with two outstanding
    mem_hold = 1'b1;
    pc_i = 32'h8;
    bus.imem_req_ready = 1'b1;
    a0 = n_acc;
    repeat (3) tick();
    check("fl_acc", 64'(n_acc - a0), 64'd2);
    flush = 1'b1;
    @(negedge clk);
    check("fl_req_valid", 64'(bus.imem_req_valid), 64'd0);
    step();
    flush = 1'b0;
    mem_hold = 1'b0;
    pc_i = 32'h40;
    d0 = n_dec;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fl_dv_quiet", 64'(bus.dec_valid), 64'd0);
      step();
    end
    bus.imem_req_ready = 1'b0;
    drain();
    check("fl_dec_seen", 64'(n_dec > d0), 64'd1);

    // Flush in the same cycle as a response
    pc_i = 32'h80;
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("fc_req_valid", 64'(bus.imem_req_valid), 64'd0);
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("fc_dv_quiet", 64'(bus.dec_valid), 64'd0);
      step();
    end
    pc_i = 32'h90;
    bus.imem_req_ready = 1'b1;
    d0 = n_dec;
    tick();
    bus.imem_req_ready = 1'b0;
    drain();
    check("fc_next_cnt", 64'(n_dec - d0), 64'd1);
    check("fc_next_pc", 64'(last_pc), 64'h90);

    // Reset with a full FIFO
    bus.dec_ready = 1'b0;
    pc_i = 32'h200;
    bus.imem_req_ready = 1'b1;
    tick();
    tick();
    bus.imem_req_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rs_full_dv", 64'(bus.dec_valid), 64'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rs_in_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("rs_in_dv", 64'(bus.dec_valid), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rs_post_dv", 64'(bus.dec_valid), 64'd0);
    check("rs_post_req_valid", 64'(bus.imem_req_valid), 64'd1);
    check("rs_post_pc", 64'(bus.dec_pc), 64'd0);
    check("rs_post_ins", 64'(bus.dec_instr), 64'd0);
    step();
    bus.dec_ready = 1'b1;
    drain();

    // Streaming
    pc_i = 32'h1000;
    bus.imem_req_ready = 1'b1;
    d0 = n_dec;
    repeat (30) tick();
    bus.imem_req_ready = 1'b0;
    drain();
    n = n_dec - d0;
    check("st_rate", 64'(n >= 18), 64'd1);
    check("st_last_pc", 64'(last_pc), 64'(32'h1000 + 32'(4 * (n - 1))));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
